// File: rtl/dff_chain_pkg.sv
// Shared encodings and helpers for the shared delay-chain scheduler.
package dff_chain_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Number of bits needed to index v distinct values (v >= 2).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dff_chain_n.sv
// DEPTH-stage data+valid D-flip-flop chain; output is the last stage.
module dff_chain_n #(
  parameter int DEPTH = 4
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic d_i,
  input  logic v_i,
  output logic d_o,
  output logic v_o
);

  logic [DEPTH-1:0] d_q;
  logic [DEPTH-1:0] v_q;

  // Shift data and valid one stage per clock; stage 0 takes the new bit.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      d_q <= '0;
      v_q <= '0;
    end else begin
      for (int s = DEPTH - 1; s > 0; s--) begin
        d_q[s] <= d_q[s-1];
        v_q[s] <= v_q[s-1];
      end
      d_q[0] <= d_i;
      v_q[0] <= v_i;
    end
  end

  assign d_o = d_q[DEPTH-1];
  assign v_o = v_q[DEPTH-1];

endmodule

// File: rtl/dff_chain_sched.sv
// Round-robin scheduler that serialises one granted word at a time, LSB
// first, through a shared DEPTH-stage delay chain and signals completion
// to the owner once the last bit has left the chain.
module dff_chain_sched
  import dff_chain_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       RST_n,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*DATA_W-1:0]    i_data,
  output logic [N_REQ-1:0]           o_gnt,
  output logic                       o_busy,
  output logic [clog2(N_REQ)-1:0]    o_owner,
  output logic                       o_sdata,
  output logic                       o_svalid,
  output logic [N_REQ-1:0]           o_done
);

  localparam int OW = clog2(N_REQ);
  localparam int BW = clog2(DATA_W + 1);
  localparam int DW = clog2(DEPTH + 1);

  state_e            state_q;
  logic [OW-1:0]     ptr_q;
  logic [OW-1:0]     owner_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic              busy_q;
  logic [BW-1:0]     bcnt_q;
  logic [DW-1:0]     dcnt_q;
  logic [DATA_W-1:0] word_q;

  logic              gnt_any;
  logic [OW-1:0]     gnt_idx;
  logic              chain_d;
  logic              chain_v;

  // Pick the first requester after the last-granted one, wrapping around.
  // Scanning from the farthest offset down lets the nearest one win.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (i_req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = OW'(idx);
      end
    end
  end

  // Control FSM: arbitration, bit/drain counters and registered pulses.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      ptr_q   <= OW'(N_REQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      bcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_any) begin
            gnt_q   <= N_REQ'(1) << gnt_idx;
            owner_q <= gnt_idx;
            ptr_q   <= gnt_idx;
            busy_q  <= 1'b1;
            bcnt_q  <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bcnt_q == BW'(DATA_W - 1)) begin
            bcnt_q  <= '0;
            dcnt_q  <= DW'(DEPTH);
            state_q <= S_DRAIN;
          end else begin
            bcnt_q <= bcnt_q + BW'(1);
          end
        end
        S_DRAIN: begin
          dcnt_q <= dcnt_q - DW'(1);
          if (dcnt_q == DW'(1)) begin
            done_q  <= N_REQ'(1) << owner_q;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Word register: capture on grant, shift right while serialising.
  always_ff @(posedge CLK) begin
    if (state_q == S_IDLE && gnt_any) begin
      word_q <= i_data[int'(gnt_idx)*DATA_W +: DATA_W];
    end else if (state_q == S_SHIFT) begin
      word_q <= word_q >> 1;
    end
  end

  assign chain_v = (state_q == S_SHIFT);
  assign chain_d = chain_v & word_q[0];

  dff_chain_n #(
    .DEPTH (DEPTH)
  ) u_chain (
    .CLK   (CLK),
    .RST_n (RST_n),
    .d_i   (chain_d),
    .v_i   (chain_v),
    .d_o   (o_sdata),
    .v_o   (o_svalid)
  );

  assign o_gnt   = gnt_q;
  assign o_done  = done_q;
  assign o_busy  = busy_q;
  assign o_owner = owner_q;

endmodule

// File: tb/tb_dff_chain_sched.sv
// Directed bench for dff_chain_sched with a serial-bit scoreboard.
module tb_dff_chain_sched;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [1:0]  i_req;
  logic [15:0] i_data;
  logic [1:0]  o_gnt;
  logic        o_busy;
  logic [0:0]  o_owner;
  logic        o_sdata;
  logic        o_svalid;
  logic [1:0]  o_done;

  logic [1:0]  e_req;
  logic [1:0]  e_data;
  logic [1:0]  e_gnt;
  logic        e_busy;
  logic [0:0]  e_owner;
  logic        e_sdata;
  logic        e_svalid;
  logic [1:0]  e_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic bitq[$];

  always #5 CLK = ~CLK;

  dff_chain_sched #(.N_REQ(2), .DATA_W(8), .DEPTH(4)) dut (
    .CLK(CLK), .RST_n(RST_n), .i_req(i_req), .i_data(i_data),
    .o_gnt(o_gnt), .o_busy(o_busy), .o_owner(o_owner),
    .o_sdata(o_sdata), .o_svalid(o_svalid), .o_done(o_done)
  );

  dff_chain_sched #(.N_REQ(2), .DATA_W(1), .DEPTH(1)) dut_edge (
    .CLK(CLK), .RST_n(RST_n), .i_req(e_req), .i_data(e_data),
    .o_gnt(e_gnt), .o_busy(e_busy), .o_owner(e_owner),
    .o_sdata(e_sdata), .o_svalid(e_svalid), .o_done(e_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) bitq.push_back(w[i]);
  endtask

  // Serial output scoreboard: every valid bit must match the next expected bit.
  always @(negedge CLK) begin
    if (RST_n && o_svalid) begin
      n_tests++;
      assert (bitq.size() != 0) else begin
        n_fail++;
        $error("FAIL sbit_unexpected: observed %0b, expected no valid bit", o_sdata);
      end
      if (bitq.size() != 0) chk("sbit", o_sdata, bitq.pop_front());
    end
  end

  // Called at the negedge after the grant edge; runs through the done cycle.
  task automatic xfer(input logic [1:0] exp_gnt, input string tag,
                      input logic [1:0] req_after, input bit pulse1);
    chk({tag, "_gnt"}, o_gnt, exp_gnt);
    chk({tag, "_owner"}, o_owner, (exp_gnt == 2'b10) ? 1 : 0);
    chk({tag, "_busy0"}, o_busy, 1);
    i_req = req_after;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (pulse1 && c == 1) i_req = 2'b10;
      if (pulse1 && c == 6) i_req = 2'b00;
      if (pulse1) chk({tag, "_nognt"}, o_gnt, 0);
      if (c == 3) chk({tag, "_svalid_pre"}, o_svalid, 0);
      if (c == 4) chk({tag, "_svalid_first"}, o_svalid, 1);
      if (c == 11) begin
        chk({tag, "_busy_last"}, o_busy, 1);
        chk({tag, "_svalid_last"}, o_svalid, 1);
        chk({tag, "_done_early"}, o_done, 0);
      end
      if (c == 12) begin
        chk({tag, "_done"}, o_done, exp_gnt);
        chk({tag, "_busy_end"}, o_busy, 0);
        chk({tag, "_svalid_end"}, o_svalid, 0);
      end
    end
  endtask

  initial begin
    RST_n  = 1'b0;
    i_req  = 2'b11;
    i_data = 16'hC35A;
    e_req  = 2'b00;
    e_data = 2'b00;

    // Reset with both requests asserted: everything quiet.
    @(negedge CLK);
    chk("rst_busy", o_busy, 0);
    chk("rst_owner", o_owner, 0);
    chk("rst_sdata", o_sdata, 0);
    chk("rst_svalid", o_svalid, 0);
    chk("rst_done", o_done, 0);
    repeat (3) begin
      @(negedge CLK);
      chk("rst_gnt", o_gnt, 0);
    end
    i_req = 2'b00;
    RST_n = 1'b1;

    // Single transfer of 8'hA5 from requester 0.
    @(negedge CLK);
    i_req  = 2'b01;
    i_data = 16'h00A5;
    push_word(8'hA5);
    @(negedge CLK);
    xfer(2'b01, "t2", 2'b00, 1'b0);
    @(negedge CLK);
    chk("t2_idle_gnt", o_gnt, 0);

    // Fresh pointer, then continuous contention: 0, 1, 0 back to back.
    RST_n = 1'b0;
    @(negedge CLK);
    RST_n  = 1'b1;
    i_req  = 2'b11;
    i_data = 16'hC33C;
    push_word(8'h3C);
    @(negedge CLK);
    xfer(2'b01, "t3a", 2'b11, 1'b0);
    push_word(8'hC3);
    @(negedge CLK);
    xfer(2'b10, "t3b", 2'b11, 1'b0);
    push_word(8'h3C);
    @(negedge CLK);
    xfer(2'b01, "t3c", 2'b00, 1'b0);
    @(negedge CLK);
    chk("t3_idle_gnt", o_gnt, 0);

    // Requester 1 pulses while busy and withdraws before IDLE.
    i_req  = 2'b01;
    i_data = 16'hFF96;
    push_word(8'h96);
    @(negedge CLK);
    xfer(2'b01, "t4", 2'b00, 1'b1);
    repeat (3) begin
      @(negedge CLK);
      chk("t4_after_gnt", o_gnt, 0);
    end

    // Reset mid-transfer right after edge E6; pending request regranted.
    i_req  = 2'b01;
    i_data = 16'h00E7;
    push_word(8'hE7);
    @(negedge CLK);
    chk("t5_gnt", o_gnt, 2'b01);
    repeat (5) @(negedge CLK);
    @(posedge CLK);
    #1 RST_n = 1'b0;
    bitq.delete();
    @(negedge CLK);
    chk("t5_rst_svalid", o_svalid, 0);
    chk("t5_rst_sdata", o_sdata, 0);
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_done", o_done, 0);
    @(negedge CLK);
    chk("t5_rst_done2", o_done, 0);
    RST_n = 1'b1;
    push_word(8'hE7);
    @(negedge CLK);
    xfer(2'b01, "t5r", 2'b00, 1'b0);
    @(negedge CLK);
    chk("sb_empty", bitq.size(), 0);

    // DATA_W=1, DEPTH=1 instance: one SHIFT cycle, one DRAIN cycle.
    e_req  = 2'b01;
    e_data = 2'b01;
    @(negedge CLK);
    chk("t6_gnt0", e_gnt, 2'b01);
    chk("t6_owner0", e_owner, 0);
    chk("t6_busy0", e_busy, 1);
    e_req = 2'b10;
    @(negedge CLK);
    chk("t6_svalid0", e_svalid, 1);
    chk("t6_sdata0", e_sdata, 1);
    chk("t6_done0_early", e_done, 0);
    @(negedge CLK);
    chk("t6_done0", e_done, 2'b01);
    chk("t6_busy0_end", e_busy, 0);
    chk("t6_svalid0_end", e_svalid, 0);
    @(negedge CLK);
    chk("t6_gnt1", e_gnt, 2'b10);
    chk("t6_owner1", e_owner, 1);
    e_req = 2'b00;
    @(negedge CLK);
    chk("t6_svalid1", e_svalid, 1);
    chk("t6_sdata1", e_sdata, 0);
    @(negedge CLK);
    chk("t6_done1", e_done, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
